scan_decoder: RTL and testbench

//  Parametrised registered binary-to-one-hot decoder with valid/ready input handshake.

---
 rtl/scan_decoder_pkg.sv | 22 ++
 rtl/scan_decoder_dwell.sv | 35 +++
 rtl/scan_decoder.sv | 112 +++++++++++
 tb/tb_scan_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared state encodings and the one-hot helper for the scan decoder.
package scan_decoder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HOLD = 2'd1;
  localparam state_t ST_SCAN = 2'd2;

  // Widest one-hot vector the helper can build; callers truncate to their width.
  localparam int ONEHOT_MAX_W = 64;

  // Zero-extended one-hot of idx; all zero when idx falls outside [0, width).
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int idx, input int width);
    logic [ONEHOT_MAX_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    if (idx >= 0 && idx < width && idx < ONEHOT_MAX_W) return one << idx;
    return '0;
  endfunction

endpackage

// File: rtl/scan_decoder_dwell.sv
// Dwell counter for scan mode: loads a reload value, counts down while enabled,
// pulses expire at zero and reloads on that same edge.
module scan_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [DWELL_W-1:0] reload,
  input  logic               enable,
  output logic               expire
);

  logic [DWELL_W-1:0] reload_q;
  logic [DWELL_W-1:0] count;

  assign expire = enable && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
      count    <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      reload_q <= reload;
      count    <= reload;
    end else if (enable) begin
      if (expire) count <= reload_q;
      else        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with valid/ready input and a walking scan mode.
// Optional macro DEC_RANGE_CHECK_EN: drop out-of-range requests and pulse err instead.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_mode,
  input  logic [DWELL_W-1:0] in_dwell,
  input  logic               scan_stop,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               busy,
  output logic               wrap,
  output logic               err,
  output logic [1:0]         state
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(OUT_W - 1);

  // Handshake: in_ready depends only on state; a request is consumed on any
  // rising edge where in_valid and in_ready are both high.
  logic             accept;
  logic             take;
  logic             out_of_range;
  logic             expire;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] next_idx;
  logic [SEL_W-1:0] start_idx;
  logic [OUT_W-1:0] oh_sel;
  logic [OUT_W-1:0] oh_start;
  logic [OUT_W-1:0] oh_next;

  assign in_ready     = (state != ST_SCAN);
  assign busy         = (state == ST_SCAN);
  assign accept       = in_valid && in_ready;
  assign out_of_range = (32'(in_sel) >= OUT_W);
  assign next_idx     = (idx == LAST) ? '0 : idx + 1'b1;
  assign start_idx    = out_of_range ? '0 : in_sel;
  assign oh_sel       = OUT_W'(onehot(int'(in_sel), OUT_W));
  assign oh_start     = OUT_W'(onehot(int'(start_idx), OUT_W));
  assign oh_next      = OUT_W'(onehot(int'(next_idx), OUT_W));

`ifdef DEC_RANGE_CHECK_EN
  assign take = accept && !out_of_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        err <= 1'b0;
    else if (clear) err <= 1'b0;
    else            err <= accept && out_of_range;
  end
`else
  assign take = accept;
  assign err  = 1'b0;
`endif

  scan_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .load   (take && in_mode),
    .reload (in_dwell),
    .enable ((state == ST_SCAN) && !scan_stop),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (state == ST_SCAN) begin
        // Stop freezes the current line; no advance on the stopping edge.
        if (scan_stop) begin
          state <= ST_HOLD;
        end else if (expire) begin
          idx  <= next_idx;
          out  <= oh_next;
          wrap <= (idx == LAST);
        end
      end else if (take) begin
        out_valid <= 1'b1;
        if (in_mode) begin
          state <= ST_SCAN;
          idx   <= start_idx;
          out   <= oh_start;
        end else begin
          state <= ST_HOLD;
          out   <= oh_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: directed vectors push expected outputs,
// a negedge monitor pops and compares, plus a narrower instance for range cases.
module tb_scan_decoder;

  localparam int SEL_W   = 3;
  localparam int OUT_W   = 8;
  localparam int DWELL_W = 8;
  localparam int OUT6_W  = 6;
  localparam int VEC_W   = OUT_W + 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_mode = 1'b0;
  logic               scan_stop = 1'b0;
  logic [SEL_W-1:0]   in_sel = '0;
  logic [DWELL_W-1:0] in_dwell = '0;
  logic               in_ready, out_valid, busy, wrap, err;
  logic [OUT_W-1:0]   out;
  logic [1:0]         state;

  logic               d6_valid = 1'b0;
  logic               d6_mode = 1'b0;
  logic [SEL_W-1:0]   d6_sel = '0;
  logic [DWELL_W-1:0] d6_dwell = '0;
  logic               d6_ready, d6_out_valid, d6_busy, d6_wrap, d6_err;
  logic [OUT6_W-1:0]  d6_out;
  logic [1:0]         d6_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  logic [VEC_W-1:0] exp_q[$];
  logic [VEC_W-1:0] mon_e;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(SEL_W), .OUT_W(OUT_W), .DWELL_W(DWELL_W)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_mode(in_mode), .in_dwell(in_dwell), .scan_stop(scan_stop),
    .out(out), .out_valid(out_valid), .busy(busy), .wrap(wrap), .err(err), .state(state)
  );

  scan_decoder #(.SEL_W(SEL_W), .OUT_W(OUT6_W), .DWELL_W(DWELL_W)) u_dut6 (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(d6_valid), .in_ready(d6_ready),
    .in_sel(d6_sel), .in_mode(d6_mode), .in_dwell(d6_dwell), .scan_stop(1'b0),
    .out(d6_out), .out_valid(d6_out_valid), .busy(d6_busy), .wrap(d6_wrap), .err(d6_err),
    .state(d6_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packed view: {err, in_ready, busy, wrap, out_valid, out}
  function automatic logic [VEC_W-1:0] vec(input logic [OUT_W-1:0] o, input logic ov,
                                           input logic b, input logic w, input logic r);
    return {1'b0, r, b, w, ov, o};
  endfunction

  task automatic cyc(input logic [VEC_W-1:0] e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic cyc6();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("onehot0", 32'($onehot0(out)), 32'd1);
      check("zero_out_not_valid", 32'((out != '0) || !out_valid), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_pop++;
        check($sformatf("vec%0d {err,rdy,busy,wrap,ov,out}", n_pop),
              32'({err, in_ready, busy, wrap, out_valid, out}), 32'(mon_e));
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_state", 32'(state), 32'd0);
    rst = 1'b0;

    // Direct decode, then clear
    in_valid = 1'b1; in_mode = 1'b0; in_sel = 3'd3;
    cyc(vec(8'h08, 1, 0, 0, 1));
    in_sel = 3'd7;
    cyc(vec(8'h80, 1, 0, 0, 1));
    in_valid = 1'b0;
    cyc(vec(8'h80, 1, 0, 0, 1));
    clear = 1'b1;
    cyc(vec(8'h00, 0, 0, 0, 1));
    clear = 1'b0;

    // Scan from 6 with dwell 2: three cycles per line, single-cycle wrap at line 0
    in_valid = 1'b1; in_mode = 1'b1; in_sel = 3'd6; in_dwell = 8'd2;
    cyc(vec(8'h40, 1, 1, 0, 0));
    in_valid = 1'b0;
    repeat (2) cyc(vec(8'h40, 1, 1, 0, 0));
    repeat (3) cyc(vec(8'h80, 1, 1, 0, 0));
    cyc(vec(8'h01, 1, 1, 1, 0));
    repeat (2) cyc(vec(8'h01, 1, 1, 0, 0));
    cyc(vec(8'h02, 1, 1, 0, 0));
    clear = 1'b1;
    cyc(vec(8'h00, 0, 0, 0, 1));
    clear = 1'b0;

    // Dwell 0 walks every cycle; stop beats a pending request
    in_valid = 1'b1; in_mode = 1'b1; in_sel = 3'd0; in_dwell = 8'd0;
    cyc(vec(8'h01, 1, 1, 0, 0));
    in_valid = 1'b0;
    cyc(vec(8'h02, 1, 1, 0, 0));
    cyc(vec(8'h04, 1, 1, 0, 0));
    cyc(vec(8'h08, 1, 1, 0, 0));
    scan_stop = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_sel = 3'd5;
    cyc(vec(8'h08, 1, 0, 0, 1));
    scan_stop = 1'b0;
    cyc(vec(8'h20, 1, 0, 0, 1));
    in_valid = 1'b0;

    // Dwell 0 wrap from the top line
    in_valid = 1'b1; in_mode = 1'b1; in_sel = 3'd7;
    cyc(vec(8'h80, 1, 1, 0, 0));
    in_valid = 1'b0;
    cyc(vec(8'h01, 1, 1, 1, 0));
    cyc(vec(8'h02, 1, 1, 0, 0));
    scan_stop = 1'b1;
    cyc(vec(8'h02, 1, 0, 0, 1));
    scan_stop = 1'b0;

    // Asynchronous reset while scanning at line 5
    in_valid = 1'b1; in_mode = 1'b1; in_sel = 3'd5; in_dwell = 8'd3;
    cyc(vec(8'h20, 1, 1, 0, 0));
    in_valid = 1'b0;
    cyc(vec(8'h20, 1, 1, 0, 0));
    wait_drain();
    #1 rst = 1'b1;
    #1;
    check("midscan_rst_out", 32'(out), 32'd0);
    check("midscan_rst_out_valid", 32'(out_valid), 32'd0);
    check("midscan_rst_busy", 32'(busy), 32'd0);
    check("midscan_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Six-line instance: out-of-range index 7
    d6_valid = 1'b1; d6_mode = 1'b0; d6_sel = 3'd2;
    cyc6();
    check("d6_direct2_out", 32'(d6_out), 32'h04);
    d6_sel = 3'd7;
    cyc6();
`ifdef DEC_RANGE_CHECK_EN
    check("d6_oor_err", 32'(d6_err), 32'd1);
    check("d6_oor_out_kept", 32'(d6_out), 32'h04);
    check("d6_oor_valid_kept", 32'(d6_out_valid), 32'd1);
`else
    check("d6_oor_err", 32'(d6_err), 32'd0);
    check("d6_oor_out", 32'(d6_out), 32'h00);
    check("d6_oor_valid", 32'(d6_out_valid), 32'd1);
`endif
    d6_valid = 1'b0;
    cyc6();
    check("d6_err_one_cycle", 32'(d6_err), 32'd0);
    d6_valid = 1'b1; d6_mode = 1'b1; d6_dwell = 8'd0;
    cyc6();
    d6_valid = 1'b0;
`ifdef DEC_RANGE_CHECK_EN
    check("d6_scan_oor_err", 32'(d6_err), 32'd1);
    check("d6_scan_oor_busy", 32'(d6_busy), 32'd0);
    check("d6_scan_oor_out", 32'(d6_out), 32'h04);
`else
    check("d6_scan_oor_start", 32'(d6_out), 32'h01);
    check("d6_scan_oor_busy", 32'(d6_busy), 32'd1);
    repeat (5) cyc6();
    check("d6_scan_line5", 32'(d6_out), 32'h20);
    cyc6();
    check("d6_scan_wrap_out", 32'(d6_out), 32'h01);
    check("d6_scan_wrap", 32'(d6_wrap), 32'd1);
`endif

    // Random traffic; the monitor checks the output invariants every cycle
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_mode   = 1'($urandom_range(0, 1));
      in_sel    = 3'($urandom_range(0, 7));
      in_dwell  = 8'($urandom_range(0, 3));
      scan_stop = ($urandom_range(0, 15) == 0);
      clear     = ($urandom_range(0, 31) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; scan_stop = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
